// File: rtl/cg_timer_sched_pkg.sv
// Shared types and helpers for the round-robin interval timer scheduler.
package cg_timer_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

  // Index width for a requester vector; a minimum of 1 keeps the ports legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cg_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module cg_rr_arbiter
  import cg_timer_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int         IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int unsigned      k;
  logic [N_REQ-1:0] req_rot;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    valid   = 1'b0;
    k       = 0;
    req_rot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k       = (32'(ptr) + i) % N_REQ;
      req_rot = req >> k;
      if (!valid && req_rot[0]) begin
        valid = 1'b1;
        idx   = IDX_W'(k);
        gnt   = N_REQ'(1) << k;
      end
    end
  end

endmodule

// File: rtl/cg_timer_sched.sv
// Shares one cycle counter among N_REQ requesters, one timed interval per grant.
module cg_timer_sched
  import cg_timer_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int         IDX_W      = idx_w(N_REQ)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_len,
  input  logic                        i_pause,
  output logic [N_REQ-1:0]            o_gnt,
  output logic [IDX_W-1:0]            o_owner,
  output logic [DATA_WIDTH-1:0]       o_count,
  output logic [N_REQ-1:0]            o_done,
  output logic                        o_busy
);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [N_REQ-1:0]      done_q, done_d;

  logic [N_REQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_valid;
  logic [DATA_WIDTH-1:0] sel_len;
  logic [IDX_W-1:0]      owner_next;
  logic                  own_req;
  logic                  terminal;

  cg_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req   (i_req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_len = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (arb_idx == IDX_W'(k)) sel_len = i_len[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
  assign own_req    = i_req[owner_q];
  assign terminal   = (count_q == len_q - DATA_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    len_d   = len_q;
    count_d = count_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d = StRun;
          owner_d = arb_idx;
          // A zero length still takes one RUN cycle.
          len_d   = (sel_len == '0) ? DATA_WIDTH'(1) : sel_len;
          count_d = '0;
          gnt_d   = arb_gnt;
        end
      end
      StRun: begin
        // Abort wins over terminal count; the count is left where it stopped.
        if (!own_req) begin
          state_d = StIdle;
          gnt_d   = '0;
          ptr_d   = owner_next;
        end else if (!i_pause) begin
          if (terminal) begin
            state_d = StDone;
            gnt_d   = '0;
            done_d  = N_REQ'(1) << owner_q;
            ptr_d   = owner_next;
          end else begin
            count_d = count_q + DATA_WIDTH'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      len_q   <= '0;
      count_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      len_q   <= len_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_owner = owner_q;
  assign o_count = count_q;
  assign o_done  = done_q;
  assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_cg_timer_sched.sv
// Randomized and directed bench for cg_timer_sched against a behavioural scheduler model.
module tb_cg_timer_sched;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] len;
  logic            pause;
  logic [N-1:0]    gnt;
  logic [1:0]      owner;
  logic [DW-1:0]   count;
  logic [N-1:0]    done;
  logic            busy;

  cg_timer_sched #(
    .N_REQ      (N),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_len   (len),
    .i_pause (pause),
    .o_gnt   (gnt),
    .o_owner (owner),
    .o_count (count),
    .o_done  (done),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: phase 0 waiting, 1 timing an interval, 2 reporting completion.
  int m_phase, m_owner, m_len, m_cnt, m_ptr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_phase = 0; m_owner = 0; m_len = 0; m_cnt = 0; m_ptr = 0;
    end else begin
      case (m_phase)
        0: begin
          for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (req[k]) begin
              m_owner = k;
              m_len   = int'(len[k*DW +: DW]);
              if (m_len == 0) m_len = 1;
              m_cnt   = 0;
              m_phase = 1;
              break;
            end
          end
        end
        1: begin
          if (!req[m_owner]) begin
            m_phase = 0;
            m_ptr   = (m_owner + 1) % N;
          end else if (!pause) begin
            if (m_cnt == m_len - 1) begin
              m_phase = 2;
              m_ptr   = (m_owner + 1) % N;
            end else begin
              m_cnt++;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("gnt",   64'(gnt),   (m_phase == 1) ? (64'd1 << m_owner) : 64'd0);
    check("done",  64'(done),  (m_phase == 2) ? (64'd1 << m_owner) : 64'd0);
    check("owner", 64'(owner), 64'(m_owner));
    check("count", 64'(count), 64'(m_cnt));
    check("busy",  64'(busy),  64'(m_phase != 0));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; pause = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_len(input int k, input int v);
    len[k*DW +: DW] = DW'(v);
  endtask

  // Runs until a done pulse, then drops the finished request.
  task automatic run_to_done(input int budget, output int gnt_cyc, output int lat,
                             output logic [N-1:0] dval);
    int first;
    bit seen;
    first = -1; seen = 0; gnt_cyc = 0; lat = 0; dval = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (gnt != '0) begin
        gnt_cyc++;
        if (first < 0) first = cyc;
      end
      if (done != '0) begin
        seen = 1;
        dval = done;
        lat  = cyc - first;
        req  = req & ~done;
      end
    end
    check("done_within_budget", 64'(seen), 64'd1);
  endtask

  initial begin
    int g, l, t0, nd;
    int dcyc[5];
    int didx[5];
    logic [N-1:0] d;
    bit reached;

    rst = 1'b1; req = '0; pause = 1'b0; len = '0;
    m_phase = 0; m_owner = 0; m_len = 0; m_cnt = 0; m_ptr = 0;

    // Single request, length 5.
    do_reset();
    check("reset_busy", 64'(busy), 64'd0);
    set_len(0, 5);
    req = 4'b0001;
    run_to_done(20, g, l, d);
    check("t1_gnt_cycles", 64'(g), 64'd5);
    check("t1_done", 64'(d), 64'b0001);
    check("t1_latency", 64'(l), 64'd5);
    step();
    check("t1_busy_low", 64'(busy), 64'd0);

    // All requesting, length 3: rotation and 5-cycle spacing.
    do_reset();
    for (int k = 0; k < N; k++) set_len(k, 3);
    req = 4'b1111;
    nd = 0;
    for (int i = 0; i < 60 && nd < 5; i++) begin
      step();
      if (done != '0) begin
        dcyc[nd] = cyc;
        didx[nd] = 0;
        for (int k = 0; k < N; k++) if (done[k]) didx[nd] = k;
        nd++;
      end
    end
    check("t2_num_done", 64'(nd), 64'd5);
    for (int j = 0; j < nd; j++) begin
      check("t2_order", 64'(didx[j]), 64'(j % N));
      if (j > 0) check("t2_spacing", 64'(dcyc[j] - dcyc[j-1]), 64'd5);
    end
    req = '0;

    // Zero length acts as one.
    do_reset();
    set_len(2, 0);
    req = 4'b0100;
    run_to_done(10, g, l, d);
    check("t3_gnt_cycles", 64'(g), 64'd1);
    check("t3_done", 64'(d), 64'b0100);

    // Pause for 3 cycles mid-run.
    do_reset();
    set_len(0, 4);
    req = 4'b0001;
    step();
    t0 = cyc;
    check("t4_gnt", 64'(gnt), 64'b0001);
    step();
    pause = 1'b1;
    repeat (3) step();
    check("t4_count_held", 64'(count), 64'd1);
    pause = 1'b0;
    run_to_done(20, g, l, d);
    check("t4_latency", 64'(cyc - t0), 64'd7);

    // Owner 1 aborts at count 2; next grant follows index 1.
    do_reset();
    set_len(1, 10);
    set_len(3, 5);
    req = 4'b0010;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step();
      if (gnt == 4'b0010 && count == 2) reached = 1;
    end
    check("t5_reach_count2", 64'(reached), 64'd1);
    req = 4'b1001;
    step();
    check("t5_abort_no_done", 64'(done), 64'd0);
    check("t5_abort_idle", 64'(busy), 64'd0);
    check("t5_count_held", 64'(count), 64'd2);
    step();
    check("t5_next_gnt", 64'(gnt), 64'b1000);
    req = '0;

    // Reset at count 7 mid-run, then re-arbitration from requester 0.
    do_reset();
    set_len(2, 20);
    req = 4'b0100;
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      step();
      if (count == 7) reached = 1;
    end
    check("t6_reach_count7", 64'(reached), 64'd1);
    rst = 1'b1;
    step();
    check("t6_rst_gnt", 64'(gnt), 64'd0);
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    req = 4'b0101;
    step();
    check("t6_rearb", 64'(gnt), 64'b0001);
    req = '0;

    // Largest length for the width.
    do_reset();
    set_len(3, 255);
    req = 4'b1000;
    run_to_done(300, g, l, d);
    check("t7_gnt_cycles", 64'(g), 64'd255);
    check("t7_done", 64'(d), 64'b1000);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) req = N'($urandom);
      for (int k = 0; k < N; k++) set_len(k, int'($urandom_range(7)));
      pause = ($urandom_range(3) == 0);
      rst   = ($urandom_range(99) == 0);
      step();
      if (done != '0 && $urandom_range(3) != 0) req = req & ~done;
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
